// File: rtl/decode_regfile.sv
// Y86-64 decode stage: register ID selection, 15x64 register file with
// E/M/W forwarding, and the E pipeline register.
module decode_regfile #(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   D_stat,
    input  logic [3:0]   D_icode,
    input  logic [3:0]   D_ifun,
    input  logic [3:0]   D_rA,
    input  logic [3:0]   D_rB,
    input  logic [W-1:0] D_valC,
    input  logic [W-1:0] D_valP,
    input  logic [3:0]   e_dstE,
    input  logic [W-1:0] e_valE,
    input  logic [3:0]   M_dstE,
    input  logic [3:0]   M_dstM,
    input  logic [W-1:0] M_valE,
    input  logic [W-1:0] m_valM,
    input  logic [3:0]   W_dstE,
    input  logic [3:0]   W_dstM,
    input  logic [W-1:0] W_valE,
    input  logic [W-1:0] W_valM,
    input  logic         E_bubble,
    output logic [3:0]   d_srcA,
    output logic [3:0]   d_srcB,
    output logic [1:0]   E_stat,
    output logic [3:0]   E_icode,
    output logic [3:0]   E_ifun,
    output logic [W-1:0] E_valC,
    output logic [W-1:0] E_valA,
    output logic [W-1:0] E_valB,
    output logic [3:0]   E_dstE,
    output logic [3:0]   E_dstM,
    output logic [3:0]   E_srcA,
    output logic [3:0]   E_srcB
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [1:0]   stat;
        logic [3:0]   icode;
        logic [3:0]   ifun;
        logic [W-1:0] valC;
        logic [W-1:0] valA;
        logic [W-1:0] valB;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
        logic [3:0]   srcA;
        logic [3:0]   srcB;
    } ereg_t;

    localparam ereg_t BUBBLE = '{stat: 2'd0, icode: 4'h1, ifun: 4'h0,
                                 valC: '0, valA: '0, valB: '0,
                                 dstE: RNONE, dstM: RNONE,
                                 srcA: RNONE, srcB: RNONE};

    logic [3:0]   w_srcA, w_srcB, w_dstE, w_dstM;
    logic [W-1:0] w_rdA, w_rdB, w_valA, w_valB;
    logic [W-1:0] r_regs [NREG];
    ereg_t        r_E, w_Enext;

    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: w_srcA = D_rA;
            4'h9, 4'hB:             w_srcA = RRSP;
            default:                w_srcA = RNONE;
        endcase
        case (D_icode)
            4'h4, 4'h5, 4'h6:       w_srcB = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_srcB = RRSP;
            default:                w_srcB = RNONE;
        endcase
        case (D_icode)
            4'h2, 4'h3, 4'h6:       w_dstE = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_dstE = RRSP;
            default:                w_dstE = RNONE;
        endcase
        case (D_icode)
            4'h5, 4'hB:             w_dstM = D_rA;
            default:                w_dstM = RNONE;
        endcase
    end

    assign w_rdA = (int'(w_srcA) < NREG) ? r_regs[w_srcA] : '0;
    assign w_rdB = (int'(w_srcB) < NREG) ? r_regs[w_srcB] : '0;

    // Youngest producer wins; a source of F reads 0 and never matches.
    function automatic logic [W-1:0] fwd(input logic [3:0] src, input logic [W-1:0] rd);
        if (src == RNONE)       return '0;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return rd;
    endfunction

    always_comb begin
        w_valA = fwd(w_srcA, w_rdA);
        w_valB = fwd(w_srcB, w_rdB);
        if (D_icode == 4'h7 || D_icode == 4'h8)
            w_valA = D_valP;
    end

    // valM beats valE on a shared destination so popq %rsp keeps the loaded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (W_dstM == 4'(i))      r_regs[i] <= W_valM;
                else if (W_dstE == 4'(i)) r_regs[i] <= W_valE;
            end
        end
    end

    always_comb begin
        w_Enext = BUBBLE;
        if (!E_bubble) begin
            w_Enext.stat  = D_stat;
            w_Enext.icode = D_icode;
            w_Enext.ifun  = D_ifun;
            w_Enext.valC  = D_valC;
            w_Enext.valA  = w_valA;
            w_Enext.valB  = w_valB;
            w_Enext.dstE  = w_dstE;
            w_Enext.dstM  = w_dstM;
            w_Enext.srcA  = w_srcA;
            w_Enext.srcB  = w_srcB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_E <= BUBBLE;
        else        r_E <= w_Enext;
    end

    assign d_srcA  = w_srcA;
    assign d_srcB  = w_srcB;
    assign E_stat  = r_E.stat;
    assign E_icode = r_E.icode;
    assign E_ifun  = r_E.ifun;
    assign E_valC  = r_E.valC;
    assign E_valA  = r_E.valA;
    assign E_valB  = r_E.valB;
    assign E_dstE  = r_E.dstE;
    assign E_dstM  = r_E.dstM;
    assign E_srcA  = r_E.srcA;
    assign E_srcB  = r_E.srcB;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: reset, write/read, forwarding priority,
// popq %rsp, call/ret operand selection, bubble and RNONE writes.
module tb_decode_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic        E_bubble;
    logic [3:0]  d_srcA, d_srcB;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    int checks   = 0;
    int failures = 0;

    decode_regfile #(.NREG(15), .W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .E_bubble(E_bubble), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_stat = 2'd0; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = '0; D_valP = '0;
        e_dstE = 4'hF; e_valE = '0;
        M_dstE = 4'hF; M_dstM = 4'hF; M_valE = '0; m_valM = '0;
        W_dstE = 4'hF; W_dstM = 4'hF; W_valE = '0; W_valM = '0;
        E_bubble = 1'b0;
    endtask

    task automatic dsel(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
        D_icode = icode; D_rA = ra; D_rB = rb;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Load a real instruction and seed %rax before the mid-cycle reset.
        D_stat = 2'd2; D_ifun = 4'h3; D_valC = 64'hCAFE;
        dsel(4'h6, 4'h1, 4'hF);
        W_dstE = 4'h0; W_valE = 64'h99;
        tick();
        chk("load_icode", {60'd0, E_icode}, 64'h6);
        chk("load_stat",  {62'd0, E_stat},  64'h2);
        chk("load_ifun",  {60'd0, E_ifun},  64'h3);
        chk("load_valC",  E_valC, 64'hCAFE);
        chk("load_srcA",  {60'd0, E_srcA}, 64'h1);

        // Asynchronous reset mid-cycle; a write attempted during reset is dropped.
        idle();
        W_dstE = 4'h1; W_valE = 64'h77;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_icode", {60'd0, E_icode}, 64'h1);
        chk("rst_dstE",  {60'd0, E_dstE},  64'hF);
        chk("rst_valA",  E_valA, 64'h0);
        tick();
        idle();
        rst_n = 1'b1;
        dsel(4'h6, 4'h0, 4'h1);
        tick();
        chk("rst_rax_cleared", E_valA, 64'h0);
        chk("rst_write_suppr", E_valB, 64'h0);

        // Write %rbx then read it next cycle.
        idle();
        W_dstE = 4'h3; W_valE = 64'h1234;
        tick();
        idle();
        dsel(4'h6, 4'h3, 4'hF);
        tick();
        chk("wr_rd_valA", E_valA, 64'h1234);
        chk("wr_rd_valB", E_valB, 64'h0);
        chk("wr_rd_dstE", {60'd0, E_dstE}, 64'hF);

        // Forwarding priority on %rdx.
        idle();
        W_dstE = 4'h2; W_valE = 64'h5;
        tick();
        dsel(4'h2, 4'h2, 4'h7);
        W_valE = 64'hC;
        e_dstE = 4'h2; e_valE = 64'hA;
        M_dstE = 4'h2; M_valE = 64'hB;
        tick();
        chk("fwd_e",      E_valA, 64'hA);
        chk("rrmov_dstE", {60'd0, E_dstE}, 64'h7);
        chk("rrmov_srcB", {60'd0, E_srcB}, 64'hF);
        e_dstE = 4'hF;
        tick();
        chk("fwd_M", E_valA, 64'hB);
        M_dstE = 4'hF;
        tick();
        chk("fwd_W", E_valA, 64'hC);
        W_valE = 64'hD;
        tick();
        chk("fwd_W_over_reg", E_valA, 64'hD);
        W_dstE = 4'hF;
        M_dstE = 4'h2; M_valE = 64'hB;
        M_dstM = 4'h2; m_valM = 64'h33;
        tick();
        chk("fwd_mM_over_ME", E_valA, 64'h33);
        M_dstE = 4'hF; M_dstM = 4'hF;
        W_dstE = 4'h2; W_valE = 64'h45;
        W_dstM = 4'h2; W_valM = 64'h44;
        tick();
        chk("fwd_WM_over_WE", E_valA, 64'h44);
        W_dstE = 4'hF; W_dstM = 4'hF;
        tick();
        chk("reg_WM_won", E_valA, 64'h44);

        // popq %rsp: both W ports target %rsp.
        idle();
        W_dstE = 4'h4; W_valE = 64'h108;
        W_dstM = 4'h4; W_valM = 64'h55;
        tick();
        idle();
        dsel(4'h6, 4'h4, 4'hF);
        tick();
        chk("popq_rsp", E_valA, 64'h55);

        // call: valA = valP, valB = forwarded %rsp.
        idle();
        dsel(4'h8, 4'hF, 4'hF);
        D_valP = 64'h40;
        M_dstE = 4'h4; M_valE = 64'h200;
        tick();
        chk("call_valA", E_valA, 64'h40);
        chk("call_valB", E_valB, 64'h200);
        chk("call_dstE", {60'd0, E_dstE}, 64'h4);
        chk("call_srcA", {60'd0, E_srcA}, 64'hF);
        chk("call_srcB", {60'd0, E_srcB}, 64'h4);

        // ret reads %rsp from storage on both ports.
        idle();
        dsel(4'h9, 4'hF, 4'hF);
        tick();
        chk("ret_valA", E_valA, 64'h55);
        chk("ret_valB", E_valB, 64'h55);

        // popq %rbx: dstM = rA, dstE = %rsp.
        dsel(4'hB, 4'h3, 4'hF);
        tick();
        chk("popq_dstM", {60'd0, E_dstM}, 64'h3);
        chk("popq_dstE", {60'd0, E_dstE}, 64'h4);

        // mrmovq: srcA is F so valA is 0 even with an F destination in flight.
        idle();
        dsel(4'h5, 4'h2, 4'h3);
        e_valE = 64'h999;
        tick();
        chk("mrmov_valA", E_valA, 64'h0);
        chk("mrmov_valB", E_valB, 64'h1234);
        chk("mrmov_dstM", {60'd0, E_dstM}, 64'h2);

        // Bubble with a concurrent W write.
        idle();
        E_bubble = 1'b1;
        dsel(4'h6, 4'h3, 4'h3);
        D_stat = 2'd1;
        W_dstE = 4'h5; W_valE = 64'hABC;
        tick();
        chk("bub_icode", {60'd0, E_icode}, 64'h1);
        chk("bub_dstE",  {60'd0, E_dstE},  64'hF);
        chk("bub_dstM",  {60'd0, E_dstM},  64'hF);
        chk("bub_valA",  E_valA, 64'h0);
        chk("bub_stat",  {62'd0, E_stat}, 64'h0);
        idle();
        dsel(4'h6, 4'h5, 4'hF);
        tick();
        chk("bub_write_kept", E_valA, 64'hABC);

        // Write to RNONE must not touch storage.
        idle();
        W_valE = 64'hDEAD; W_valM = 64'hBEEF;
        tick();
        idle();
        dsel(4'h6, 4'hE, 4'h0);
        tick();
        chk("rnone_r14", E_valA, 64'h0);
        chk("rnone_r0",  E_valB, 64'h0);
        dsel(4'h6, 4'h3, 4'h4);
        tick();
        chk("rnone_r3", E_valA, 64'h1234);
        chk("rnone_r4", E_valB, 64'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_regfile.md
# decode_regfile

Decode stage and architectural register file of the pipelined Y86-64 core. It selects the source and destination register IDs from the D-stage instruction and reads fifteen 64-bit registers through two read ports. It forwards in-flight results from E, M and W stages and latches the decoded operands into the E pipeline register. The W stage drives its write port; it is the reader-side counterpart of write-back and the sole owner of register storage.

## Interface
Parameters:
- `NREG`, 15: architectural registers, IDs 0..14; ID 4'hF = RNONE.
- `W`, 64: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `D_stat`  in  2  fetch status: AOK=0, HLT=1, ADR=2, INS=3.
- `D_icode`, `D_ifun`  in  4 each  instruction code and function.
- `D_rA`, `D_rB`  in  4 each  register specifiers.
- `D_valC`, `D_valP`  in  64 each  constant and next PC.
- `e_dstE`  in  4  execute-stage destination, after the Cnd gate.
- `e_valE`  in  64  execute-stage result.
- `M_dstE`, `M_dstM`  in  4 each  memory-stage destinations.
- `M_valE`  in  64  memory-stage ALU result.
- `m_valM`  in  64  memory-stage load data.
- `W_dstE`, `W_dstM`  in  4 each  write-back destinations.
- `W_valE`, `W_valM`  in  64 each  write-back data.
- `E_bubble`  in  1  load a bubble into the E register this edge.
- `d_srcA`, `d_srcB`  out  4 each  combinational source IDs, for the hazard unit.
- `E_stat`  out  2  registered.
- `E_icode`, `E_ifun`  out  4 each  registered.
- `E_valC`, `E_valA`, `E_valB`  out  64 each  registered.
- `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB`  out  4 each  registered.

## Operation
- Source and destination ID selection is combinational from `D_icode`. Any icode not listed yields F.
  - srcA = rA for icode 2, 4, 6, A.
  - srcA = 4 (%rsp) for icode 9, B.
  - srcB = rB for icode 4, 5, 6.
  - srcB = 4 for icode 8, 9, A, B.
  - dstE = rB for icode 2, 3, 6.
  - dstE = 4 for icode 8, 9, A, B.
  - dstM = rA for icode 5, B.
- Register read: source ID F reads 0. Reads are asynchronous from storage.
- valA selection, first match wins:
  1. icode 7 or 8: D_valP.
  2. srcA==e_dstE: e_valE.
  3. srcA==M_dstM: m_valM.
  4. srcA==M_dstE: M_valE.
  5. srcA==W_dstM: W_valM.
  6. srcA==W_dstE: W_valE.
  7. Otherwise: register value.
- valB uses the same chain without rule 1.
- A match requires srcX != F. A destination of F never matches.
- Register write happens on the rising edge.
  - `W_dstE` != F writes `W_valE`.
  - `W_dstM` != F writes `W_valM`.
  - When `W_dstE`==`W_dstM` != F, `W_valM` wins (popq %rsp semantics).
- E register load, every edge:
  - `E_bubble`=1: load the bubble value.
  - Otherwise: load D_stat, D_icode, D_ifun, D_valC, selected valA/valB, and dstE/dstM/srcA/srcB.
- Bubble value: stat=AOK, icode=1 (nop), ifun=0, all data 0, all register IDs F.
- No stall input. The E register loads every cycle; upstream stall is expressed by the hazard unit asserting `E_bubble`.

## Timing
- Reset (`rst_n`=0), asynchronous, takes effect immediately without a clock edge:
  - All 15 registers clear to 0.
  - The E register takes the bubble value.
  - Writes are suppressed while reset is asserted.
- Latency:
  - A D-stage value appears on E outputs 1 cycle later.
  - A W write is visible in storage from the next cycle. In the same cycle it is supplied via the W forward path, so no write-before-read ordering is required.
- Reset release mid-program: first edge with `rst_n`=1 loads the E register normally. No partial write survives.
- Simultaneous W write and D read of the same register: the forwarded W value is used. E stage, then M stage, shadows W.
- Write to ID F: ignored. Storage is unchanged and nothing is corrupted.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → E_icode=1, E_dstE=F and E_valA=0 immediately; reading %rax (0) afterwards returns 0.
- Write then read: W_dstE=3, W_valE=0x1234 at edge N; at N+1 D_icode=6, rA=3, rB=F → E_valA=0x1234 after edge N+1; E_valB=0.
- Forward priority: %rdx (2) = 5 in storage; e_dstE=2 (e_valE=0xA), M_dstE=2 (M_valE=0xB), W_dstE=2 (W_valE=0xC); D_icode=2, rA=2 → E_valA=0xA.
  - Drop e_dstE to F → E_valA=0xB.
  - Drop M_dstE to F → E_valA=0xC.
- popq %rsp: W_dstE=4/W_valE=0x108 and W_dstM=4/W_valM=0x55 on the same edge → %rsp reads 0x55.
- call: D_icode=8, D_valP=0x40, rsp forwarded as 0x200 from M_dstE → E_valA=0x40, E_valB=0x200, E_dstE=4, E_srcA=F.
- Bubble: E_bubble=1 with D_icode=6 valid → E_icode=1, E_dstE=F, E_dstM=F; the register file still accepts a concurrent W write.
